// File: rtl/conv_mem_sequencer.sv
// Loads a 4x4 input matrix and 3x3 filter into memory_module from a valid/ready stream, then
// issues the stride-1 3x3 convolution read schedule. Optional macro FILTER_KEEP_EN adds keep_filter.
module conv_mem_sequencer #(
    parameter int DATA_W = 8,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef FILTER_KEEP_EN
    input  logic              keep_filter,
`endif
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_w,
    output logic [1:0]        en_INP,
    output logic [1:0]        en_FIL,
    output logic [AW-1:0]     addr_A0,
    output logic [AW-1:0]     addr_A1,
    output logic [AW-1:0]     addr_A2,
    output logic [AW-1:0]     addr_F0,
    output logic [AW-1:0]     addr_F1,
    output logic [AW-1:0]     addr_F2,
    output logic              mac_valid,
    output logic              mac_first,
    output logic              mac_last,
    output logic [1:0]        out_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_F, S_CONV, S_FIN} state_t;

    localparam logic [1:0] EN_IDLE  = 2'b00;
    localparam logic [1:0] EN_READ  = 2'b10;
    localparam logic [1:0] EN_WRITE = 2'b11;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              r_q, r_d, c_q, c_d;
    logic [1:0]        k_q, k_d;
`ifdef FILTER_KEEP_EN
    logic              keep_q, keep_d;
`endif

    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] data_w_q, data_w_d;
    logic [1:0]        en_inp_q, en_inp_d, en_fil_q, en_fil_d;
    logic [AW-1:0]     addr_a_q [3];
    logic [AW-1:0]     addr_a_d [3];
    logic [AW-1:0]     addr_f_q [3];
    logic [AW-1:0]     addr_f_d [3];
    logic              mac_valid_q, mac_valid_d;
    logic              mac_first_q, mac_first_d;
    logic              mac_last_q, mac_last_d;
    logic [1:0]        out_idx_q, out_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              hs;
    logic [AW-1:0]     row_base, filt_base;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        c_d         = c_q;
        k_d         = k_q;
`ifdef FILTER_KEEP_EN
        keep_d      = keep_q;
`endif
        data_w_d    = '0;
        en_inp_d    = EN_IDLE;
        en_fil_d    = EN_IDLE;
        mac_valid_d = 1'b0;
        mac_first_d = 1'b0;
        mac_last_d  = 1'b0;
        out_idx_d   = '0;
        done_d      = 1'b0;
        for (int unsigned j = 0; j < 3; j++) begin
            addr_a_d[j] = '0;
            addr_f_d[j] = '0;
        end

        hs        = in_valid & in_ready_q;
        row_base  = AW'((int'(k_q) + int'(r_q)) * 4);
        filt_base = AW'(int'(k_q) * 3);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_A;
                    cnt_d   = '0;
                    r_d     = 1'b0;
                    c_d     = 1'b0;
                    k_d     = '0;
`ifdef FILTER_KEEP_EN
                    keep_d  = keep_filter;
`endif
                end
            end
            S_LOAD_A: begin
                if (hs) begin
                    en_inp_d    = EN_WRITE;
                    addr_a_d[0] = AW'(cnt_q);
                    data_w_d    = in_data;
                    if (cnt_q == 4'd15) begin
                        cnt_d = '0;
`ifdef FILTER_KEEP_EN
                        state_d = keep_q ? S_CONV : S_LOAD_F;
`else
                        state_d = S_LOAD_F;
`endif
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_LOAD_F: begin
                if (hs) begin
                    en_fil_d    = EN_WRITE;
                    addr_f_d[0] = AW'(cnt_q);
                    data_w_d    = in_data;
                    if (cnt_q == 4'd8) begin
                        cnt_d   = '0;
                        state_d = S_CONV;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_CONV: begin
                en_inp_d    = EN_READ;
                en_fil_d    = EN_READ;
                mac_valid_d = 1'b1;
                mac_first_d = (k_q == 2'd0);
                mac_last_d  = (k_q == 2'd2);
                out_idx_d   = {r_q, c_q};
                for (int unsigned j = 0; j < 3; j++) begin
                    addr_a_d[j] = row_base + AW'(c_q) + AW'(j);
                    addr_f_d[j] = filt_base + AW'(j);
                end
                // k steps fastest, then c, then r; the final row of output (1,1) ends the job
                if (k_q == 2'd2) begin
                    k_d = '0;
                    if (c_q) begin
                        c_d = 1'b0;
                        if (r_q) begin
                            r_d     = 1'b0;
                            state_d = S_FIN;
                        end else begin
                            r_d = 1'b1;
                        end
                    end else begin
                        c_d = 1'b1;
                    end
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LOAD_A) || (state_d == S_LOAD_F);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            r_q         <= 1'b0;
            c_q         <= 1'b0;
            k_q         <= '0;
`ifdef FILTER_KEEP_EN
            keep_q      <= 1'b0;
`endif
            in_ready_q  <= 1'b0;
            data_w_q    <= '0;
            en_inp_q    <= EN_IDLE;
            en_fil_q    <= EN_IDLE;
            addr_a_q    <= '{default: '0};
            addr_f_q    <= '{default: '0};
            mac_valid_q <= 1'b0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
            out_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            c_q         <= c_d;
            k_q         <= k_d;
`ifdef FILTER_KEEP_EN
            keep_q      <= keep_d;
`endif
            in_ready_q  <= in_ready_d;
            data_w_q    <= data_w_d;
            en_inp_q    <= en_inp_d;
            en_fil_q    <= en_fil_d;
            addr_a_q    <= addr_a_d;
            addr_f_q    <= addr_f_d;
            mac_valid_q <= mac_valid_d;
            mac_first_q <= mac_first_d;
            mac_last_q  <= mac_last_d;
            out_idx_q   <= out_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign data_w    = data_w_q;
    assign en_INP    = en_inp_q;
    assign en_FIL    = en_fil_q;
    assign addr_A0   = addr_a_q[0];
    assign addr_A1   = addr_a_q[1];
    assign addr_A2   = addr_a_q[2];
    assign addr_F0   = addr_f_q[0];
    assign addr_F1   = addr_f_q[1];
    assign addr_F2   = addr_f_q[2];
    assign mac_valid = mac_valid_q;
    assign mac_first = mac_first_q;
    assign mac_last  = mac_last_q;
    assign out_idx   = out_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_mem_sequencer.sv
// Bench for conv_mem_sequencer: randomized jobs checked cycle by cycle against a timing model
// derived from the accepted-word times. Define FILTER_KEEP_EN to also exercise keep_filter.
module tb_conv_mem_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, keep_filter;
    logic [7:0] in_data, data_w;
    logic       in_ready, mac_valid, mac_first, mac_last, busy, done;
    logic [1:0] en_INP, en_FIL, out_idx;
    logic [3:0] addr_A0, addr_A1, addr_A2, addr_F0, addr_F1, addr_F2;

    always #5 clk = ~clk;

    conv_mem_sequencer #(.DATA_W(8), .AW(4)) dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef FILTER_KEEP_EN
        .keep_filter(keep_filter),
`endif
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .data_w(data_w),
        .en_INP(en_INP), .en_FIL(en_FIL),
        .addr_A0(addr_A0), .addr_A1(addr_A1), .addr_A2(addr_A2),
        .addr_F0(addr_F0), .addr_F1(addr_F1), .addr_F2(addr_F2),
        .mac_valid(mac_valid), .mac_first(mac_first), .mac_last(mac_last),
        .out_idx(out_idx), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic       in_ready, busy, done;
        logic [1:0] en_i, en_f;
        logic [7:0] data;
        logic [3:0] a0, a1, a2, f0, f1, f2;
        logic       mv, first, last;
        logic [1:0] idx;
    } snap_t;

    int unsigned n_pass, n_total;
    snap_t       got[$];
    int          acc_t[$];
    logic [7:0]  words[25];
    int          t_rst;

    function automatic snap_t sample();
        snap_t s;
        s.in_ready = in_ready; s.busy = busy; s.done = done;
        s.en_i = en_INP; s.en_f = en_FIL; s.data = data_w;
        s.a0 = addr_A0; s.a1 = addr_A1; s.a2 = addr_A2;
        s.f0 = addr_F0; s.f1 = addr_F1; s.f2 = addr_F2;
        s.mv = mac_valid; s.first = mac_first; s.last = mac_last; s.idx = out_idx;
        return s;
    endfunction

    // Expected outputs in cycle t (cycle 0 = start sampled), given the times words were accepted:
    // each write shows one cycle after its handshake, conv reads run from last word +2 for 12 cycles.
    function automatic snap_t exp_at(int t, int nw);
        snap_t e = '0;
        int tl = acc_t[nw-1];
        if (t_rst >= 0 && t > t_rst) return e;
        e.in_ready = (t >= 1 && t <= tl);
        e.busy     = (t >= 1 && t <= tl + 13);
        e.done     = (t == tl + 14);
        for (int i = 0; i < nw; i++) begin
            if (acc_t[i] + 1 == t) begin
                if (i < 16) begin e.en_i = 2'b11; e.a0 = 4'(i); end
                else begin e.en_f = 2'b11; e.f0 = 4'(i - 16); end
                e.data = words[i];
            end
        end
        if (t >= tl + 2 && t <= tl + 13) begin
            int n = t - tl - 2;
            int r = n / 6;
            int c = (n / 3) % 2;
            int k = n % 3;
            e.en_i = 2'b10; e.en_f = 2'b10; e.mv = 1'b1;
            e.first = (k == 0); e.last = (k == 2); e.idx = 2'(r * 2 + c);
            e.a0 = 4'((r + k) * 4 + c); e.a1 = 4'((r + k) * 4 + c + 1); e.a2 = 4'((r + k) * 4 + c + 2);
            e.f0 = 4'(k * 3); e.f1 = 4'(k * 3 + 1); e.f2 = 4'(k * 3 + 2);
        end
        return e;
    endfunction

    // Clears fields that carry no meaning under the expected enables.
    function automatic snap_t mask(snap_t s, snap_t e);
        snap_t m = s;
        if (!(e.en_i == 2'b11 || e.mv)) m.a0 = '0;
        if (!(e.en_f == 2'b11 || e.mv)) m.f0 = '0;
        if (!e.mv) begin m.a1 = '0; m.a2 = '0; m.f1 = '0; m.f2 = '0; m.first = 1'b0; m.last = 1'b0; m.idx = '0; end
        if (!(e.en_i == 2'b11 || e.en_f == 2'b11)) m.data = '0;
        return m;
    endfunction

    // Drives one job from cycle 0 and records a snapshot per cycle; acceptance follows the model.
    task automatic run_job(input int nw, input bit kp, input int stall_pct, input int rst_conv, input bit fixed);
        int n = 0;
        int tl = -1;
        int t = 0;
        got.delete(); acc_t.delete(); t_rst = -1;
        for (int i = 0; i < 25; i++) words[i] = fixed ? 8'((i < 16) ? i : i - 15) : 8'($urandom);
        @(posedge clk); #1;
        start = 1'b1; keep_filter = kp; in_valid = 1'b1; in_data = 8'($urandom);
        forever begin
            @(negedge clk);
            got.push_back(sample());
            if (t >= 1 && n < nw && in_valid) begin
                acc_t.push_back(t);
                n++;
                if (n == nw) tl = t;
            end
            @(posedge clk); #1;
            t++;
            rst = 1'b0;
            if (tl >= 0 && t > tl + 16) break;
            start       = (n < nw) ? 1'($urandom) : 1'b0;
            keep_filter = 1'($urandom);
            in_valid    = (n < nw) ? ($urandom_range(99) >= stall_pct) : 1'($urandom);
            in_data     = (n < nw) ? words[n] : 8'($urandom);
            if (rst_conv >= 0 && tl >= 0 && t == tl + 2 + rst_conv) begin
                rst = 1'b1;
                t_rst = t;
            end
        end
        start = 1'b0; in_valid = 1'b0; keep_filter = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_total++;
            if (sample() !== '0) $display("FAIL reset cyc=%0d got=%h exp=0", i, sample());
            else n_pass++;
            if (i == 1) begin rst = 1'b0; start = 1'b0; in_valid = 1'b0; end
        end
    endtask

    task automatic test_full_job();
        int dc = -1;
        run_job(25, 1'b0, 0, -1, 1'b1);
        for (int t = 0; t < got.size(); t++) begin
            snap_t e, g;
            e = exp_at(t, 25);
            g = mask(got[t], e);
            e = mask(e, e);
            n_total++;
            if (g !== e) $display("FAIL full_job cyc=%0d got=%h exp=%h", t, g, e);
            else n_pass++;
            if (got[t].done && dc < 0) dc = t;
        end
        n_total++;
        if (dc != 39) $display("FAIL full_job_done_cycle got=%0d exp=39", dc);
        else n_pass++;
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 3; j++) begin
            run_job(25, 1'b0, 40, -1, 1'b0);
            for (int t = 0; t < got.size(); t++) begin
                snap_t e, g;
                e = exp_at(t, 25);
                g = mask(got[t], e);
                e = mask(e, e);
                n_total++;
                if (g !== e) $display("FAIL random_job%0d cyc=%0d got=%h exp=%h", j, t, g, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        bit prev = 1'b0;
        logic [7:0] prevd = '0;
        int wr = 0;
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            bit ok;
            @(posedge clk); #1;
            start = 1'b0; in_valid = pat[c-1]; in_data = 8'($urandom);
            @(negedge clk);
            if (prev) ok = (en_INP === 2'b11) && (addr_A0 === 4'(wr)) && (data_w === prevd);
            else ok = (en_INP === 2'b00);
            ok = ok && (in_ready === 1'b1) && (busy === 1'b1) && (en_FIL === 2'b00);
            n_total++;
            if (!ok) $display("FAIL backpressure cyc=%0d en_INP=%b addr=%0d data=%h in_ready=%b exp_write=%0b exp_addr=%0d exp_data=%h",
                              c, en_INP, addr_A0, data_w, in_ready, prev, wr, prevd);
            else n_pass++;
            if (prev) wr++;
            prev = in_valid; prevd = in_data;
        end
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_rst_mid_conv();
        run_job(25, 1'b0, 20, 5, 1'b0);
        for (int t = 0; t < got.size(); t++) begin
            snap_t e, g;
            e = exp_at(t, 25);
            g = mask(got[t], e);
            e = mask(e, e);
            n_total++;
            if (g !== e) $display("FAIL rst_mid_conv cyc=%0d got=%h exp=%h", t, g, e);
            else n_pass++;
        end
        n_total++;
        if (got[t_rst + 1] !== '0) $display("FAIL rst_mid_conv_zero got=%h exp=0", got[t_rst + 1]);
        else n_pass++;
        run_job(25, 1'b0, 20, -1, 1'b0);
        for (int t = 0; t < got.size(); t++) begin
            snap_t e, g;
            e = exp_at(t, 25);
            g = mask(got[t], e);
            e = mask(e, e);
            n_total++;
            if (g !== e) $display("FAIL after_rst_job cyc=%0d got=%h exp=%h", t, g, e);
            else n_pass++;
        end
    endtask

`ifdef FILTER_KEEP_EN
    task automatic test_keep_filter();
        int fw = 0;
        int dc = -1;
        run_job(16, 1'b1, 0, -1, 1'b0);
        for (int t = 0; t < got.size(); t++) begin
            snap_t e, g;
            e = exp_at(t, 16);
            g = mask(got[t], e);
            e = mask(e, e);
            n_total++;
            if (g !== e) $display("FAIL keep_filter cyc=%0d got=%h exp=%h", t, g, e);
            else n_pass++;
            if (got[t].en_f == 2'b11) fw++;
            if (got[t].done && dc < 0) dc = t;
        end
        n_total++;
        if (fw != 0 || dc != 30) $display("FAIL keep_filter_summary filter_writes=%0d done_cycle=%0d exp 0 and 30", fw, dc);
        else n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; keep_filter = 1'b0;
        n_pass = 0; n_total = 0; t_rst = -1;
        test_reset();
        test_full_job();
        test_random_jobs();
        test_backpressure();
        test_rst_mid_conv();
`ifdef FILTER_KEEP_EN
        test_keep_filter();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
